ssd_scan_decoder: RTL and testbench

//  Inverse of the hex-to-seven-segment path. Watches a multiplexed, active-low

---
 rtl/ssd_pkg.sv | 19 +
 rtl/ssd_pattern_decode.sv | 24 ++
 rtl/ssd_scan_decoder.sv | 215 +++++++++++++++++++++
 tb/tb_ssd_scan_decoder.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ssd_pkg.sv
// Shared seven-segment definitions: pattern table, blank code and slot FSM states.
package ssd_pkg;

  // Active-low segment patterns for hex digits 0..F (bit0=a .. bit6=g).
  localparam logic [6:0] SSD_ARRAY [0:15] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  // All segments dark.
  localparam logic [6:0] SSD_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    S_WAIT,
    S_SETTLE,
    S_HELD
  } ssd_slot_state_t;

endpackage

// File: rtl/ssd_pattern_decode.sv
// Combinational inverse of the hex-to-segment table: pattern -> nibble, blank, illegal.
module ssd_pattern_decode
  import ssd_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] nibble,
  output logic       blank,
  output logic       illegal
);

  // Table lookup; anything that is neither a table entry nor blank is illegal.
  always_comb begin
    nibble  = 4'h0;
    blank   = (seg == SSD_BLANK);
    illegal = (seg != SSD_BLANK);
    for (int i = 0; i < 16; i++) begin
      if (seg == SSD_ARRAY[i]) begin
        nibble  = 4'(i);
        illegal = 1'b0;
      end
    end
  end

endmodule

// File: rtl/ssd_scan_decoder.sv
// Watches a multiplexed active-low seven-segment scan bus and rebuilds full frames
// of per-digit nibbles, handed off over a valid/ready interface.
module ssd_scan_decoder
  import ssd_pkg::*;
#(
  parameter int NUM_DIGITS    = 6,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [6:0]              seg_in,
  input  logic [NUM_DIGITS-1:0]   an_in,
  input  logic                    frame_ready,
  output logic                    frame_valid,
  output logic [4*NUM_DIGITS-1:0] digits_out,
  output logic [NUM_DIGITS-1:0]   blank_out,
  output logic [NUM_DIGITS-1:0]   illegal_out,
  output logic                    overrun
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);

  // Input registers
  logic [6:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;

  // Slot FSM state
  ssd_slot_state_t       state_q, state_d;
  logic [6:0]            lat_seg_q, lat_seg_d;
  logic [NUM_DIGITS-1:0] lat_an_q, lat_an_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  cap_en;

  // Capture and seen registers
  logic [4*NUM_DIGITS-1:0] cap_digits_q, cap_digits_d;
  logic [NUM_DIGITS-1:0]   cap_blank_q, cap_blank_d;
  logic [NUM_DIGITS-1:0]   cap_illegal_q, cap_illegal_d;
  logic [NUM_DIGITS-1:0]   seen_q, seen_d;

  // Output handshake registers
  logic [4*NUM_DIGITS-1:0] out_digits_q, out_digits_d;
  logic [NUM_DIGITS-1:0]   out_blank_q, out_blank_d;
  logic [NUM_DIGITS-1:0]   out_illegal_q, out_illegal_d;
  logic                    valid_q, valid_d;
  logic                    overrun_q, overrun_d;

  logic                  changed;
  logic                  an_legal;
  logic [CW-1:0]         cnt_inc;
  logic [NUM_DIGITS-1:0] cap_sel;
  logic                  frame_done;
  logic [3:0]            dec_nibble;
  logic                  dec_blank;
  logic                  dec_illegal;

  assign seg_d      = seg_in;
  assign an_d       = an_in;
  assign changed    = (seg_q != lat_seg_q) || (an_q != lat_an_q);
  assign an_legal   = $onehot(~an_q);
  assign cnt_inc    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
  assign cap_sel    = ~lat_an_q;
  assign frame_done = &seen_q;

  // The latched pattern is equal to seg_q whenever a capture fires.
  ssd_pattern_decode u_decode (
    .seg     (lat_seg_q),
    .nibble  (dec_nibble),
    .blank   (dec_blank),
    .illegal (dec_illegal)
  );

  // Slot FSM next state: settle on a legal slot, capture once stable, hold until change.
  always_comb begin
    state_d   = state_q;
    lat_seg_d = lat_seg_q;
    lat_an_d  = lat_an_q;
    cnt_d     = cnt_q;
    cap_en    = 1'b0;
    case (state_q)
      S_WAIT: begin
        if (an_legal) begin
          lat_seg_d = seg_q;
          lat_an_d  = an_q;
          cnt_d     = CNT_ONE;
          state_d   = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (changed) begin
          if (an_legal) begin
            lat_seg_d = seg_q;
            lat_an_d  = an_q;
            cnt_d     = CNT_ONE;
          end else begin
            cnt_d   = '0;
            state_d = S_WAIT;
          end
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc >= CNT_MAX) begin
            cap_en  = 1'b1;
            state_d = S_HELD;
          end
        end
      end
      S_HELD: begin
        if (changed) begin
          if (an_legal) begin
            lat_seg_d = seg_q;
            lat_an_d  = an_q;
            cnt_d     = CNT_ONE;
            state_d   = S_SETTLE;
          end else begin
            cnt_d   = '0;
            state_d = S_WAIT;
          end
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
    endcase
  end

  // Capture registers: write the selected digit, clear seen once a frame is handed on.
  always_comb begin
    cap_digits_d  = cap_digits_q;
    cap_blank_d   = cap_blank_q;
    cap_illegal_d = cap_illegal_q;
    seen_d        = frame_done ? '0 : seen_q;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (cap_en && cap_sel[i]) begin
        cap_digits_d[4*i +: 4] = dec_nibble;
        cap_blank_d[i]         = dec_blank;
        cap_illegal_d[i]       = dec_illegal;
        seen_d[i]              = 1'b1;
      end
    end
  end

  // Output handshake: copy a completed frame unless an unaccepted one is still held.
  always_comb begin
    out_digits_d  = out_digits_q;
    out_blank_d   = out_blank_q;
    out_illegal_d = out_illegal_q;
    valid_d       = valid_q;
    overrun_d     = 1'b0;
    if (frame_done) begin
      if (!valid_q || frame_ready) begin
        out_digits_d  = cap_digits_q;
        out_blank_d   = cap_blank_q;
        out_illegal_d = cap_illegal_q;
        valid_d       = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && frame_ready) begin
      valid_d = 1'b0;
    end
  end

  // Slot FSM, input and stability registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      seg_q     <= SSD_BLANK;
      an_q      <= '1;
      state_q   <= S_WAIT;
      lat_seg_q <= SSD_BLANK;
      lat_an_q  <= '1;
      cnt_q     <= '0;
    end else begin
      seg_q     <= seg_d;
      an_q      <= an_d;
      state_q   <= state_d;
      lat_seg_q <= lat_seg_d;
      lat_an_q  <= lat_an_d;
      cnt_q     <= cnt_d;
    end
  end

  // Capture, seen and output handshake registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      cap_digits_q  <= '0;
      cap_blank_q   <= '0;
      cap_illegal_q <= '0;
      seen_q        <= '0;
      out_digits_q  <= '0;
      out_blank_q   <= '0;
      out_illegal_q <= '0;
      valid_q       <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      cap_digits_q  <= cap_digits_d;
      cap_blank_q   <= cap_blank_d;
      cap_illegal_q <= cap_illegal_d;
      seen_q        <= seen_d;
      out_digits_q  <= out_digits_d;
      out_blank_q   <= out_blank_d;
      out_illegal_q <= out_illegal_d;
      valid_q       <= valid_d;
      overrun_q     <= overrun_d;
    end
  end

  assign frame_valid = valid_q;
  assign digits_out  = out_digits_q;
  assign blank_out   = out_blank_q;
  assign illegal_out = out_illegal_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_ssd_scan_decoder.sv
// Directed bench for ssd_scan_decoder: a frame table plus hand-built corner sequences.
module tb_ssd_scan_decoder;

  logic        clk;
  logic        reset;
  logic [6:0]  seg_in;
  logic [5:0]  an_in;
  logic        frame_ready;
  logic        frame_valid;
  logic [23:0] digits_out;
  logic [5:0]  blank_out;
  logic [5:0]  illegal_out;
  logic        overrun;

  int checks;
  int failures;
  int rise_cnt;
  int ovr_cnt;
  logic        valid_prev;
  logic [23:0] last_digits;

  typedef struct packed {
    logic [41:0] segs;
    logic [23:0] digits;
    logic [5:0]  blank;
    logic [5:0]  illegal;
  } vec_t;

  vec_t vecs [5];

  ssd_scan_decoder #(.NUM_DIGITS(6), .STABLE_CYCLES(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .seg_in      (seg_in),
    .an_in       (an_in),
    .frame_ready (frame_ready),
    .frame_valid (frame_valid),
    .digits_out  (digits_out),
    .blank_out   (blank_out),
    .illegal_out (illegal_out),
    .overrun     (overrun)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count frame_valid rising edges and overrun pulses on the falling edge.
  always @(negedge clk) begin
    if (frame_valid && !valid_prev) begin
      rise_cnt    = rise_cnt + 1;
      last_digits = digits_out;
    end
    if (overrun) ovr_cnt = ovr_cnt + 1;
    valid_prev = frame_valid;
  end

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    an_in  = 6'h3F;
    seg_in = 7'h7F;
    tick(n);
  endtask

  // Scan the digits selected by mask; digit 0 holds hold0 cycles, others hold cycles.
  task automatic applyStimulus(input logic [41:0] segs, input logic [5:0] mask,
                               input int hold0, input int hold);
    logic [5:0] a;
    for (int i = 0; i < 6; i++) begin
      if (mask[i]) begin
        a      = 6'h3F;
        a[i]   = 1'b0;
        an_in  = a;
        seg_in = segs[7*i +: 7];
        tick((i == 0) ? hold0 : hold);
      end
    end
    idle(4);
  endtask

  task automatic doReset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
  endtask

  int r0;
  int o0;

  initial begin
    checks      = 0;
    failures    = 0;
    rise_cnt    = 0;
    ovr_cnt     = 0;
    valid_prev  = 1'b0;
    last_digits = '0;
    reset       = 1'b1;
    seg_in      = 7'h7F;
    an_in       = 6'h3F;
    frame_ready = 1'b0;

    vecs[0] = '{segs: {7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40},
                digits: 24'h543210, blank: 6'b000000, illegal: 6'b000000};
    vecs[1] = '{segs: {7'h0E, 7'h7E, 7'h0E, 7'h7F, 7'h0E, 7'h0E},
                digits: 24'hF0F0FF, blank: 6'b000100, illegal: 6'b010000};
    vecs[2] = '{segs: {7'h03, 7'h08, 7'h18, 7'h00, 7'h78, 7'h02},
                digits: 24'hBA9876, blank: 6'b000000, illegal: 6'b000000};
    vecs[3] = '{segs: {7'h7F, 7'h40, 7'h0E, 7'h06, 7'h21, 7'h46},
                digits: 24'h00FEDC, blank: 6'b100000, illegal: 6'b000000};
    vecs[4] = '{segs: {7'h7F, 7'h7F, 7'h01, 7'h7F, 7'h7F, 7'h7F},
                digits: 24'h000000, blank: 6'b110111, illegal: 6'b001000};

    // Reset state
    tick(2);
    checkOutput("reset_valid", 32'(frame_valid), 32'd0);
    checkOutput("reset_digits", 32'(digits_out), 32'd0);
    checkOutput("reset_blank", 32'(blank_out), 32'd0);
    checkOutput("reset_illegal", 32'(illegal_out), 32'd0);
    checkOutput("reset_overrun", 32'(overrun), 32'd0);
    reset = 1'b0;
    tick(1);

    // Frame table, consumer stalled until the frame is inspected
    for (int r = 0; r < 5; r++) begin
      frame_ready = 1'b0;
      applyStimulus(vecs[r].segs, 6'h3F, 6, 6);
      checkOutput($sformatf("row%0d_valid", r), 32'(frame_valid), 32'd1);
      checkOutput($sformatf("row%0d_digits", r), 32'(digits_out), 32'(vecs[r].digits));
      checkOutput($sformatf("row%0d_blank", r), 32'(blank_out), 32'(vecs[r].blank));
      checkOutput($sformatf("row%0d_illegal", r), 32'(illegal_out), 32'(vecs[r].illegal));
      frame_ready = 1'b1;
      tick(1);
      frame_ready = 1'b0;
      checkOutput($sformatf("row%0d_accept", r), 32'(frame_valid), 32'd0);
    end

    // Ready held high: exactly one frame with the 0..5 pattern
    doReset();
    frame_ready = 1'b1;
    r0 = rise_cnt;
    applyStimulus(vecs[0].segs, 6'h3F, 6, 6);
    idle(2);
    checkOutput("ready_frames", 32'(rise_cnt - r0), 32'd1);
    checkOutput("ready_digits", 32'(last_digits), 32'h543210);
    checkOutput("ready_valid_drop", 32'(frame_valid), 32'd0);

    // Digit 0 one cycle short of stable, then exactly stable
    doReset();
    r0 = rise_cnt;
    applyStimulus(vecs[2].segs, 6'h3F, 3, 6);
    applyStimulus(vecs[2].segs, 6'h3F, 3, 6);
    checkOutput("short_hold_frames", 32'(rise_cnt - r0), 32'd0);
    applyStimulus(vecs[2].segs, 6'h3F, 4, 6);
    idle(2);
    checkOutput("min_hold_frames", 32'(rise_cnt - r0), 32'd1);
    checkOutput("min_hold_digits", 32'(last_digits), 32'hBA9876);

    // Overrun: two frames while stalled, first is held, one pulse
    doReset();
    frame_ready = 1'b0;
    r0 = rise_cnt;
    o0 = ovr_cnt;
    applyStimulus(vecs[0].segs, 6'h3F, 6, 6);
    applyStimulus(vecs[2].segs, 6'h3F, 6, 6);
    idle(2);
    checkOutput("ovr_valid", 32'(frame_valid), 32'd1);
    checkOutput("ovr_digits_held", 32'(digits_out), 32'h543210);
    checkOutput("ovr_pulses", 32'(ovr_cnt - o0), 32'd1);
    checkOutput("ovr_frames", 32'(rise_cnt - r0), 32'd1);
    frame_ready = 1'b1;
    tick(1);
    frame_ready = 1'b0;
    checkOutput("ovr_accept", 32'(frame_valid), 32'd0);

    // Two anodes low must not capture; reset mid-frame discards everything
    doReset();
    frame_ready = 1'b0;
    applyStimulus(vecs[0].segs, 6'h3F, 6, 6);
    o0 = ovr_cnt;
    applyStimulus(vecs[2].segs, 6'h3E, 6, 6);
    an_in  = 6'b111100;
    seg_in = 7'h02;
    tick(10);
    idle(4);
    checkOutput("dual_an_overrun", 32'(ovr_cnt - o0), 32'd0);
    checkOutput("dual_an_digits", 32'(digits_out), 32'h543210);
    reset = 1'b1;
    tick(1);
    checkOutput("midreset_valid", 32'(frame_valid), 32'd0);
    checkOutput("midreset_digits", 32'(digits_out), 32'd0);
    checkOutput("midreset_blank", 32'(blank_out), 32'd0);
    checkOutput("midreset_overrun", 32'(overrun), 32'd0);
    reset = 1'b0;
    r0 = rise_cnt;
    applyStimulus(vecs[2].segs, 6'h01, 6, 6);
    idle(2);
    checkOutput("midreset_partial", 32'(rise_cnt - r0), 32'd0);
    applyStimulus(vecs[3].segs, 6'h3F, 6, 6);
    checkOutput("midreset_fresh_valid", 32'(frame_valid), 32'd1);
    checkOutput("midreset_fresh_digits", 32'(digits_out), 32'h00FEDC);
    frame_ready = 1'b1;
    tick(1);
    frame_ready = 1'b0;

    // Digit 1 flickering faster than the stability window is never captured
    doReset();
    frame_ready = 1'b1;
    r0 = rise_cnt;
    applyStimulus(vecs[0].segs, 6'h3D, 6, 6);
    an_in = 6'b111101;
    for (int k = 0; k < 10; k++) begin
      seg_in = (k % 2 == 0) ? 7'h40 : 7'h79;
      tick(2);
    end
    idle(4);
    checkOutput("flicker_frames", 32'(rise_cnt - r0), 32'd0);
    applyStimulus(vecs[0].segs, 6'h02, 6, 6);
    idle(2);
    checkOutput("flicker_recover", 32'(rise_cnt - r0), 32'd1);
    checkOutput("flicker_digits", 32'(last_digits), 32'h543210);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
